// File: rtl/dice_roller_if.sv
// Roll request and dice result bundle between the button/game side and the dice roller.
// The requester owns roll; the roller owns everything else.
interface dice_roller_if;
  logic       roll;
  logic [2:0] dice1;
  logic [2:0] dice2;
  logic       clock_en;
  logic [3:0] sum;
  logic       rolling;
  logic       done;

  modport master (output roll, input dice1, dice2, clock_en, sum, rolling, done);
  modport slave  (input roll, output dice1, dice2, clock_en, sum, rolling, done);
endinterface

// File: rtl/dice_roller.sv
// Two-dice roller: spins LFSR-derived faces for ROLL_CYCLES after a roll edge, then holds.
// Every dice change comes with a one-cycle clock_en so the display latches it.
module dice_roller #(
  parameter int unsigned ROLL_CYCLES = 16,
  parameter int unsigned TICK_DIV    = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic          clock,
  input  logic          reset,
  dice_roller_if.slave  bus
);

  localparam int unsigned KW = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES) : 1;
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(ROLL_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, ROLL, HOLD} state_t;

  state_t        state;
  logic [15:0]   lfsr;
  logic          roll_q;
  logic [KW-1:0] k;
  logic [TW-1:0] tick;
  logic [2:0]    d1;
  logic [2:0]    d2;
  logic [3:0]    s;
  logic          strobe;
  logic          rolling_r;
  logic          done_r;

  logic [15:0]   lfsr_next;
  logic [2:0]    cand1;
  logic [2:0]    cand2;
  logic [2:0]    new1;
  logic [2:0]    new2;
  logic [3:0]    new_sum;
  logic [TW-1:0] tick_next;
  logic          request;

  // Candidate faces outside 1..6 leave that die unchanged.
  always_comb begin
    lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    cand1     = lfsr[2:0];
    cand2     = lfsr[5:3];
    new1      = (cand1 >= 3'd1 && cand1 <= 3'd6) ? cand1 : d1;
    new2      = (cand2 >= 3'd1 && cand2 <= 3'd6) ? cand2 : d2;
    new_sum   = 4'(new1) + 4'(new2);
    tick_next = (tick == T_LAST) ? '0 : tick + TW'(1);
    request   = bus.roll & ~roll_q;
  end

  // Outputs are registered one edge ahead so new dice appear in the strobe cycle itself.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      lfsr      <= LFSR_SEED;
      roll_q    <= 1'b0;
      k         <= '0;
      tick      <= '0;
      d1        <= 3'd1;
      d2        <= 3'd1;
      s         <= 4'd2;
      strobe    <= 1'b0;
      rolling_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      lfsr   <= lfsr_next;
      roll_q <= bus.roll;
      strobe <= 1'b0;
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (request) begin
            state     <= ROLL;
            rolling_r <= 1'b1;
            k         <= '0;
            tick      <= '0;
            if (TICK_DIV == 1) begin
              d1     <= new1;
              d2     <= new2;
              s      <= new_sum;
              strobe <= 1'b1;
            end
          end
        end
        ROLL: begin
          if (k == K_LAST) begin
            state     <= HOLD;
            rolling_r <= 1'b0;
            done_r    <= 1'b1;
          end else begin
            k    <= k + KW'(1);
            tick <= tick_next;
            if (tick_next == T_LAST) begin
              d1     <= new1;
              d2     <= new2;
              s      <= new_sum;
              strobe <= 1'b1;
            end
          end
        end
        HOLD: begin
          // A held button parks here so it cannot retrigger.
          if (!bus.roll) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dice1    = d1;
  assign bus.dice2    = d2;
  assign bus.sum      = s;
  assign bus.clock_en = strobe;
  assign bus.rolling  = rolling_r;
  assign bus.done     = done_r;

endmodule

// File: tb/tb_dice_roller.sv
// Bench for dice_roller: predicted dice pairs are queued at each press and checked on every clock_en.
// A second instance runs the single-update configuration (ROLL_CYCLES == TICK_DIV == 4).
module tb_dice_roller;

  localparam int unsigned RC   = 16;
  localparam int unsigned TD   = 4;
  localparam int unsigned RC2  = 4;
  localparam int unsigned TD2  = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clock = 1'b0;
  logic reset;

  dice_roller_if bus ();
  dice_roller_if bus2 ();

  dice_roller #(.ROLL_CYCLES(RC), .TICK_DIV(TD), .LFSR_SEED(SEED)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  dice_roller #(.ROLL_CYCLES(RC2), .TICK_DIV(TD2), .LFSR_SEED(SEED)) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          bad   = 0;
  logic        mon_en = 1'b0;
  logic [15:0] m_lfsr;
  logic [9:0]  sbq[$];
  logic [9:0]  mon_exp;
  logic [2:0]  exp_d1, exp_d2, exp2_d1, exp2_d2;
  logic [7:0]  seen1, seen2;

  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference LFSR: seeded by reset, advances every clock.
  always @(posedge clock) m_lfsr <= reset ? SEED : step(m_lfsr);

  // Predicts all strobe values of one roll from the LFSR value in the request cycle.
  task automatic predict(input logic [15:0] l0, input int unsigned rc, input int unsigned td,
                         inout logic [2:0] a, inout logic [2:0] b, input bit push,
                         output logic [9:0] last);
    logic [15:0] l;
    logic [2:0]  c1, c2;
    l    = l0;
    last = '0;
    for (int k = 0; k < int'(rc); k++) begin
      if (k > 0) l = step(l);
      if (k % int'(td) == int'(td) - 1) begin
        c1 = l[2:0];
        c2 = l[5:3];
        if (c1 >= 3'd1 && c1 <= 3'd6) a = c1;
        if (c2 >= 3'd1 && c2 <= 3'd6) b = c2;
        last = {a, b, 4'(a) + 4'(b)};
        if (push) sbq.push_back(last);
      end
    end
  endtask

  // Scoreboard and per-cycle invariants on the main instance.
  always @(negedge clock) begin
    if (mon_en) begin
      total++;
      if (bus.clock_en === 1'b1 && bus.done === 1'b1) begin
        bad++;
        $display("FAIL overlap: clock_en=%b done=%b, required not both high", bus.clock_en, bus.done);
      end
      total++;
      if ($isunknown({bus.dice1, bus.dice2, bus.sum}) || bus.dice1 < 3'd1 || bus.dice1 > 3'd6 ||
          bus.dice2 < 3'd1 || bus.dice2 > 3'd6 || bus.sum !== 4'(bus.dice1) + 4'(bus.dice2)) begin
        bad++;
        $display("FAIL range_sum: dice1=%0d dice2=%0d sum=%0d, required faces 1..6 and sum=dice1+dice2",
                 bus.dice1, bus.dice2, bus.sum);
      end
      if (bus.clock_en === 1'b1) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL sb_underflow: clock_en seen with dice %0d/%0d, required no strobe", bus.dice1, bus.dice2);
        end else begin
          mon_exp = sbq.pop_front();
          if ({bus.dice1, bus.dice2, bus.sum} !== mon_exp) begin
            bad++;
            $display("FAIL sb_value: got %0d/%0d sum %0d, required %0d/%0d sum %0d",
                     bus.dice1, bus.dice2, bus.sum, mon_exp[9:7], mon_exp[6:4], mon_exp[3:0]);
          end
        end
        seen1[bus.dice1] = 1'b1;
        seen2[bus.dice2] = 1'b1;
      end
    end
  end

  task automatic clear_expect();
    sbq.delete();
    exp_d1 = 3'd1; exp_d2 = 3'd1; exp2_d1 = 3'd1; exp2_d2 = 3'd1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    clear_expect();
    repeat (2) @(negedge clock);
    reset  = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      total++;
      if ({bus.dice1, bus.dice2, bus.sum, bus.clock_en, bus.rolling, bus.done} !== {3'd1, 3'd1, 4'd2, 3'b000}) begin
        bad++;
        $display("FAIL reset_idle: got d=%0d/%0d sum=%0d ce=%b rolling=%b done=%b, required 1/1 2 0 0 0",
                 bus.dice1, bus.dice2, bus.sum, bus.clock_en, bus.rolling, bus.done);
      end
    end
  endtask

  task automatic test_single_roll();
    logic [31:0] rmask, cemask;
    logic [9:0]  last;
    int          ndone, dpos;
    rmask = '0; cemask = '0; ndone = 0; dpos = 0;
    @(negedge clock);
    bus.roll = 1'b1;
    predict(m_lfsr, RC, TD, exp_d1, exp_d2, 1'b1, last);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (i == 1) bus.roll = 1'b0;
      if (bus.rolling === 1'b1) rmask[i] = 1'b1;
      if (bus.clock_en === 1'b1) cemask[i] = 1'b1;
      if (bus.done === 1'b1) begin ndone++; dpos = i; end
    end
    total++;
    if (rmask !== 32'h0001_FFFE) begin bad++; $display("FAIL single_rolling: got %h, required 0001fffe", rmask); end
    total++;
    if (cemask !== 32'h0001_1110) begin bad++; $display("FAIL single_strobes: got %h, required 00011110", cemask); end
    total++;
    if (ndone != 1 || dpos != 17) begin bad++; $display("FAIL single_done: got count %0d at %0d, required 1 at 17", ndone, dpos); end
    total++;
    if (sbq.size() != 0) begin bad++; $display("FAIL single_sb_left: got %0d, required 0", sbq.size()); end
  endtask

  task automatic test_held();
    logic [9:0] last;
    int         rcnt, cecnt, ndone, dpos, late;
    rcnt = 0; cecnt = 0; ndone = 0; dpos = 0; late = 0;
    @(negedge clock);
    bus.roll = 1'b1;
    predict(m_lfsr, RC, TD, exp_d1, exp_d2, 1'b1, last);
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      if (bus.rolling === 1'b1) rcnt++;
      if (bus.clock_en === 1'b1) cecnt++;
      if (bus.done === 1'b1) begin ndone++; dpos = i; end
    end
    bus.roll = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (bus.rolling !== 1'b0 || bus.clock_en !== 1'b0 || bus.done !== 1'b0) late++;
    end
    total++;
    if (rcnt != 16 || cecnt != 4) begin bad++; $display("FAIL held_one_roll: got rolling %0d strobes %0d, required 16 4", rcnt, cecnt); end
    total++;
    if (ndone != 1 || dpos != 17) begin bad++; $display("FAIL held_done: got count %0d at %0d, required 1 at 17", ndone, dpos); end
    total++;
    if (late != 0) begin bad++; $display("FAIL held_release: got %0d active cycles, required 0", late); end
    ndone = 0; dpos = 0;
    bus.roll = 1'b1;
    predict(m_lfsr, RC, TD, exp_d1, exp_d2, 1'b1, last);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (i == 1) bus.roll = 1'b0;
      if (bus.done === 1'b1) begin ndone++; dpos = i; end
    end
    total++;
    if (ndone != 1 || dpos != 17) begin bad++; $display("FAIL held_repress: got count %0d at %0d, required 1 at 17", ndone, dpos); end
  endtask

  task automatic test_short();
    logic [9:0]  e2, got;
    logic [31:0] cemask;
    int          ndone, dpos, rcnt;
    for (int n = 0; n < 3; n++) begin
      cemask = '0; ndone = 0; dpos = 0; rcnt = 0; got = '0;
      @(negedge clock);
      bus2.roll = 1'b1;
      predict(m_lfsr, RC2, TD2, exp2_d1, exp2_d2, 1'b0, e2);
      for (int i = 1; i <= 8; i++) begin
        @(negedge clock);
        if (i == 1) bus2.roll = 1'b0;
        if (bus2.rolling === 1'b1) rcnt++;
        if (bus2.clock_en === 1'b1) begin cemask[i] = 1'b1; got = {bus2.dice1, bus2.dice2, bus2.sum}; end
        if (bus2.done === 1'b1) begin ndone++; dpos = i; end
      end
      total++;
      if (cemask !== 32'h0000_0010 || rcnt != 4) begin bad++; $display("FAIL short_strobe: got mask %h rolling %0d, required 00000010 4", cemask, rcnt); end
      total++;
      if (ndone != 1 || dpos != 5) begin bad++; $display("FAIL short_done: got count %0d at %0d, required 1 at 5", ndone, dpos); end
      total++;
      if (got !== e2) begin bad++; $display("FAIL short_value: got %h, required %h", got, e2); end
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] last;
    int         act;
    act = 0;
    @(negedge clock);
    bus.roll = 1'b1;
    predict(m_lfsr, RC, TD, exp_d1, exp_d2, 1'b1, last);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clock);
      if (i == 1) bus.roll = 1'b0;
    end
    reset = 1'b1;
    clear_expect();
    @(negedge clock);
    total++;
    if ({bus.dice1, bus.dice2, bus.sum, bus.clock_en, bus.rolling, bus.done} !== {3'd1, 3'd1, 4'd2, 3'b000}) begin
      bad++;
      $display("FAIL reset_mid: got d=%0d/%0d sum=%0d ce=%b rolling=%b done=%b, required 1/1 2 0 0 0",
               bus.dice1, bus.dice2, bus.sum, bus.clock_en, bus.rolling, bus.done);
    end
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (bus.done !== 1'b0 || bus.clock_en !== 1'b0 || bus.rolling !== 1'b0) act++;
    end
    total++;
    if (act != 0) begin bad++; $display("FAIL reset_mid_quiet: got %0d active cycles, required 0", act); end
  endtask

  task automatic test_random();
    logic [9:0] last;
    int         w;
    seen1 = '0; seen2 = '0;
    for (int n = 0; n < 2000; n++) begin
      repeat ($urandom_range(6, 1)) @(negedge clock);
      bus.roll = 1'b1;
      predict(m_lfsr, RC, TD, exp_d1, exp_d2, 1'b1, last);
      @(negedge clock);
      bus.roll = 1'b0;
      w = 0;
      while (bus.done !== 1'b1 && w < 30) begin
        @(negedge clock);
        w++;
      end
      total++;
      if (bus.done !== 1'b1) begin bad++; $display("FAIL random_timeout: roll %0d got no done in 30 cycles, required done", n); end
    end
    total++;
    if (seen1 !== 8'b0111_1110 || seen2 !== 8'b0111_1110) begin
      bad++;
      $display("FAIL random_faces: got seen1=%b seen2=%b, required 01111110 both", seen1, seen2);
    end
    total++;
    if (sbq.size() != 0) begin bad++; $display("FAIL random_sb_left: got %0d, required 0", sbq.size()); end
  endtask

  initial begin
    reset     = 1'b1;
    bus.roll  = 1'b0;
    bus2.roll = 1'b0;
    clear_expect();
    test_reset();
    test_single_roll();
    test_held();
    test_short();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
